vec3_fork: RTL
==============

// Module: vec3_fork
// PURPOSE
//  Upstream feeder for the three-operand float adder. Accepts one packed 3-element float vector per
//  AXI-Stream beat and fans it out to three independent AXI-Stream operand channels (a, b, c).
//  Each lane completes its handshake independently. A new vector is taken only when every lane of
//  the previous vector has been consumed, so operands never mix across vectors.
//  Full throughput (1 vector/cycle) when all three lanes are ready.
// PARAMETERS
//  SIZE     32   float word width per lane (bits)
//  CNT_W    16   width of the accepted-vector counter
// PORTS
//  aclk                   in   1        clock; all logic on rising edge
//  aresetn                in   1        reset, asynchronous assert, active-low
//  s_axis_vec_tdata       in   3*SIZE   packed vector: a=[SIZE-1:0], b=[2*SIZE-1:SIZE], c=[3*SIZE-1:2*SIZE]
//  s_axis_vec_tvalid      in   1        input vector valid
//  s_axis_vec_tready      out  1        input vector accepted when high with tvalid
//  m_axis_a_tdata         out  SIZE     lane a operand
//  m_axis_a_tvalid        out  1        lane a valid
//  m_axis_a_tready        in   1        lane a ready
//  m_axis_b_tdata         out  SIZE     lane b operand
//  m_axis_b_tvalid        out  1        lane b valid
//  m_axis_b_tready        in   1        lane b ready
//  m_axis_c_tdata         out  SIZE     lane c operand
//  m_axis_c_tvalid        out  1        lane c valid
//  m_axis_c_tready        in   1        lane c ready
//  vec_count              out  CNT_W    number of vectors accepted since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  State: data register vec_q[3*SIZE-1:0]; pending flags pend_a/b/c; counter cnt_q.
//  Reset (aresetn low, takes effect immediately, no clock edge needed):
//   - pend_* = 0, cnt_q = 0, vec_q = 0.
//   - All m_*_tvalid = 0. s_axis_vec_tready = 0 for as long as aresetn is low.
//   - An in-flight vector is discarded. It is not replayed after reset.
//  Outputs:
//   - m_x_tvalid = pend_x.
//   - m_x_tdata = lane x slice of vec_q. Stable while m_x_tvalid is high and m_x_tready is low.
//  Lane done term: done_x = ~pend_x | m_x_tready.
//  Input ready: s_axis_vec_tready = aresetn & done_a & done_b & done_c.
//   - This is combinational from the m_*_tready inputs. The input never waits on its own valid.
//  Accept: acc = s_axis_vec_tvalid & s_axis_vec_tready. On acc, at the next edge:
//   - vec_q <= s_axis_vec_tdata
//   - pend_a/b/c <= 1
//   - cnt_q <= cnt_q + 1, wrapping 2^CNT_W-1 -> 0
//  No accept: pend_x <= pend_x & ~m_x_tready. A lane clears on its own handshake.
//  Simultaneous drain and accept: if the last pending lanes fire in the same cycle as acc, the flags
//   are set again. Back-to-back vectors therefore run with no bubble.
//  Latency: accept edge -> all three m_*_tvalid high 1 cycle later. No combinational path from
//   s_axis_vec_tdata to any m_* output.
//  Lanes may complete in any order and on any cycles. A lane that has already completed holds
//   tvalid=0 until the next vector is accepted.
//  Empty (pend_*=0): s_axis_vec_tready=1 regardless of m_*_tready.
//  Blocked: a single lane with pend=1 and ready=0 holds s_axis_vec_tready=0 indefinitely.
// STRUCTURE
//  Shared package float_pkg:
//   - FLOAT_SIZE default (32)
//   - lane index constants LANE_A=0, LANE_B=1, LANE_C=2
//   - function lane_slice(vec, idx)
//  One sub-module, fork_lane: holds a single pending flag.
//   - inputs: set (acc), ready
//   - outputs: valid, done
//   - instantiated 3x
//  Data register and counter live in the top level.
// TESTING
//  1. All lanes ready, 4 back-to-back vectors {1.0,2.0,3.0}.. -> one vector per cycle, each lane sees
//     0x3F800000/0x40000000/0x40400000 etc. 1 cycle after accept; vec_count=4.
//  2. Hold m_c_tready=0 for 5 cycles, vector {a=0x3F800000,b=0x40000000,c=0x40400000} -> a and b
//     fire once then tvalid=0; c_tvalid=1 with stable data; s_axis_vec_tready=0 until c fires.
//  3. Lanes fire on different cycles (a@t1, b@t3, c@t2) while next vector is offered -> next vector
//     accepted in the c/b completion cycle (t3), no bubble, no lane sees a duplicate.
//  4. Assert aresetn low mid-vector with b and c pending -> tvalid a/b/c=0 immediately, tready=0
//     during reset, vec_count=0; after release, the first vector accepted cleanly.
//  5. Counter wrap with CNT_W=4: accept 17 vectors -> vec_count reads 15 then 0 then 1.
//  6. Random valid/ready on all four interfaces, 10k vectors -> scoreboard: every lane receives
//     every vector exactly once, in order, with matching data.

Source files
------------

// File: rtl/float_pkg.sv
// Shared constants for the float operand path: word size, lane indices and a lane extractor.
package float_pkg;

  localparam int FLOAT_SIZE = 32;
  localparam int NUM_LANES  = 3;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;

  // Extract lane idx from a packed three-word vector (lane a sits in the low word).
  function automatic logic [FLOAT_SIZE-1:0] lane_slice(input logic [NUM_LANES*FLOAT_SIZE-1:0] vec,
                                                       input int idx);
    return vec[idx*FLOAT_SIZE +: FLOAT_SIZE];
  endfunction

endpackage

// File: rtl/vec3_fork_if.sv
// Single AXI-Stream channel (tdata/tvalid/tready) with producer and consumer views.
interface vec3_fork_if #(
  parameter int W = 32
);

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/vec3_fork_lane.sv
// One output lane of the fork: a single pending flag that is set on accept and
// cleared by the lane's own handshake. A set wins over a same-cycle clear, which
// is what lets back-to-back vectors run without a bubble.
module fork_lane (
  input  logic aclk,
  input  logic aresetn,
  input  logic set,
  input  logic ready,
  output logic valid,
  output logic done
);

  logic pend_q;
  logic pend_d;

  // Next pending state: hold until handshake, re-arm on accept.
  always_comb begin
    pend_d = pend_q & ~ready;
    if (set) begin
      pend_d = 1'b1;
    end
  end

  // Pending flag register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign valid = pend_q;
  assign done  = ~pend_q | ready;

endmodule

// File: rtl/vec3_fork.sv
// Fans one packed three-word vector out to three independent AXI-Stream lanes.
// A new vector is taken only once every lane of the previous one has handshaken
// (or is handshaking this cycle), so operands from different vectors never mix.
module vec3_fork
  import float_pkg::*;
#(
  parameter int SIZE  = FLOAT_SIZE,
  parameter int CNT_W = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  vec3_fork_if.slave         s_axis_vec,
  vec3_fork_if.master        m_axis_a,
  vec3_fork_if.master        m_axis_b,
  vec3_fork_if.master        m_axis_c,
  output logic [CNT_W-1:0]   vec_count
);

  logic [3*SIZE-1:0]    vec_q;
  logic [3*SIZE-1:0]    vec_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_done;
  logic                 in_ready;
  logic                 acc;

  assign lane_ready[LANE_A] = m_axis_a.tready;
  assign lane_ready[LANE_B] = m_axis_b.tready;
  assign lane_ready[LANE_C] = m_axis_c.tready;

  // Ready is gated by reset so nothing is taken while the block is held in reset.
  assign in_ready          = aresetn & (&lane_done);
  assign acc               = s_axis_vec.tvalid & in_ready;
  assign s_axis_vec.tready = in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fork_lane u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .set     (acc),
      .ready   (lane_ready[i]),
      .valid   (lane_valid[i]),
      .done    (lane_done[i])
    );
  end

  // Next data/counter: capture the vector and count it on accept.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (acc) begin
      vec_d = s_axis_vec.tdata;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Data register and accepted-vector counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  // Lane outputs come only from registers; no path from input data to any lane.
  assign m_axis_a.tvalid = lane_valid[LANE_A];
  assign m_axis_b.tvalid = lane_valid[LANE_B];
  assign m_axis_c.tvalid = lane_valid[LANE_C];
  assign m_axis_a.tdata  = vec_q[LANE_A*SIZE +: SIZE];
  assign m_axis_b.tdata  = vec_q[LANE_B*SIZE +: SIZE];
  assign m_axis_c.tdata  = vec_q[LANE_C*SIZE +: SIZE];

  assign vec_count = cnt_q;

endmodule
